// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC / fetch controller: FSM state encoding,
// default reset PC and the sequential PC increment.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory port of the fetch controller.
// Request: a transfer happens in a cycle where ifu_req_valid and ifu_req_ready
// are both high; while valid is high without ready, ifu_req_addr is held stable.
// Response: ifu_rsp_valid is a one-cycle pulse with no back-pressure; the
// instruction on ifu_rsp_inst is valid only in that cycle.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_req_ready;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_rsp_inst;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
    );
endinterface

// File: rtl/pc_fetch_ctrl_next_gen.sv
// pc_next_gen: next-PC adder. Operand A is the constant increment or imm,
// operand B is the current pc or rs1; JALR (B = rs1) clears bit 0 of the sum.
module pc_next_gen
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            pc_a_src,
    input  logic            pc_b_src,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    // Select adder operands, add modulo 2^XLEN, apply JALR LSB clear
    always_comb begin
        op_a    = pc_a_src ? imm : XLEN'(PC_INC);
        op_b    = pc_b_src ? rs1 : pc;
        pc_next = op_a + op_b;
        if (pc_b_src) begin
            pc_next[0] = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, fetches one instruction at a time
// over the IFU port, holds it for execute until commit, then redirects.
// Optional macro PC_MISALIGN_CHECK_EN: a commit whose next PC is not 4-byte
// aligned keeps the old pc, halts, and raises the sticky misalign output.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              CNT_W    = 64
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_ctrl_if.master    ifu,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [XLEN-1:0]    pc,
    input  logic               exu_done,
    input  logic               pc_a_src,
    input  logic               pc_b_src,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    rs1,
    input  logic               halt,
    output logic               halted,
    output logic [CNT_W-1:0]   instret,
`ifdef PC_MISALIGN_CHECK_EN
    output logic               misalign,
`endif
    output state_t             state_dbg
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [XLEN-1:0]   pc_next;
`ifdef PC_MISALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
`endif

    pc_next_gen #(.XLEN(XLEN)) u_pc_next_gen (
        .pc_a_src (pc_a_src),
        .pc_b_src (pc_b_src),
        .pc       (pc_q),
        .imm      (imm),
        .rs1      (rs1),
        .pc_next  (pc_next)
    );

    // State, PC, instruction and retire-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            instret_q  <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            instret_q  <= instret_d;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Fetch/execute sequencing; inputs outside the owning state are ignored
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        instret_d  = instret_q;
`ifdef PC_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            S_REQ: begin
                if (ifu.ifu_req_ready) begin
                    // A same-cycle response skips the wait state
                    if (ifu.ifu_rsp_valid) begin
                        inst_d  = ifu.ifu_rsp_inst;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    inst_d  = ifu.ifu_rsp_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exu_done) begin
                    instret_d = instret_q + CNT_W'(1);
`ifdef PC_MISALIGN_CHECK_EN
                    if (pc_next[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = halt ? S_HALT : S_REQ;
                    end
`else
                    pc_d    = pc_next;
                    state_d = halt ? S_HALT : S_REQ;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign ifu.ifu_req_valid = (state_q == S_REQ);
    assign ifu.ifu_req_addr  = pc_q;
    assign inst_valid        = (state_q == S_EXEC);
    assign inst              = inst_q;
    assign pc                = pc_q;
    assign halted            = (state_q == S_HALT);
    assign instret           = instret_q;
    assign state_dbg         = state_q;
`ifdef PC_MISALIGN_CHECK_EN
    assign misalign          = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed + randomized bench for pc_fetch_ctrl with a behavioural PC model.
module tb_pc_fetch_ctrl;
  import pc_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  pc_fetch_ctrl_if #(.XLEN(32)) ifu ();

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        exu_done = 1'b0;
  logic        pc_a_src = 1'b0;
  logic        pc_b_src = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic [63:0] instret;
  state_t      state_dbg;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu        (ifu),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .exu_done   (exu_done),
    .pc_a_src   (pc_a_src),
    .pc_b_src   (pc_b_src),
    .imm        (imm),
    .rs1        (rs1),
    .halt       (halt),
    .halted     (halted),
    .instret    (instret),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign   (misalign),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [63:0] m_instret;
  bit          m_halted;
  bit          m_misalign;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RST_PC;
    m_inst     = '0;
    m_instret  = '0;
    m_halted   = 1'b0;
    m_misalign = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    ifu.ifu_rsp_inst  = '0;
    exu_done = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", pc, m_pc);
    chk("rst_req_valid", ifu.ifu_req_valid, 1);
    chk("rst_addr", ifu.ifu_req_addr, m_pc);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instret", instret, 0);
    chk("rst_state", state_dbg, S_REQ);
`ifdef PC_MISALIGN_CHECK_EN
    chk("rst_misalign", misalign, 0);
`endif
  endtask

  // Entered at a negedge with the DUT requesting; leaves with inst held.
  task automatic fetch(input logic [31:0] instw, input int stall, input bit same, input int rsp_dly);
    for (int i = 0; i < stall; i++) begin
      chk("stall_req_valid", ifu.ifu_req_valid, 1);
      chk("stall_addr", ifu.ifu_req_addr, m_pc);
      ifu.ifu_req_ready = 1'b0;
      ifu.ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu.ifu_rsp_inst  = $urandom;
      exu_done = 1'($urandom_range(0, 1));
      halt     = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("hs_req_valid", ifu.ifu_req_valid, 1);
    chk("hs_addr", ifu.ifu_req_addr, m_pc);
    chk("hs_inst_valid", inst_valid, 0);
    ifu.ifu_req_ready = 1'b1;
    ifu.ifu_rsp_valid = same;
    ifu.ifu_rsp_inst  = same ? instw : $urandom;
    exu_done = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    if (!same) begin
      for (int i = 0; i < rsp_dly; i++) begin
        chk("wait_req_valid", ifu.ifu_req_valid, 0);
        chk("wait_inst_valid", inst_valid, 0);
        exu_done = 1'($urandom_range(0, 1));
        halt     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("wait_req_valid", ifu.ifu_req_valid, 0);
      ifu.ifu_rsp_valid = 1'b1;
      ifu.ifu_rsp_inst  = instw;
      exu_done = 1'b0;
      halt     = 1'b0;
      @(negedge clk);
      ifu.ifu_rsp_valid = 1'b0;
    end
    m_inst = instw;
    chk("held_inst_valid", inst_valid, 1);
    chk("held_inst", inst, m_inst);
    chk("held_pc", pc, m_pc);
    chk("held_req_valid", ifu.ifu_req_valid, 0);
  endtask

  // Entered at a negedge with inst held; commits it and checks the redirect.
  task automatic execute(input bit a, input bit b, input logic [31:0] im, input logic [31:0] r,
                         input bit h, input int hold);
    logic [31:0] sum;
    for (int i = 0; i < hold; i++) begin
      exu_done = 1'b0;
      halt     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exec_valid", inst_valid, 1);
      chk("exec_pc", pc, m_pc);
      chk("exec_inst", inst, m_inst);
    end
    exu_done = 1'b1;
    pc_a_src = a;
    pc_b_src = b;
    imm      = im;
    rs1      = r;
    halt     = h;
    @(negedge clk);
    exu_done = 1'b0;
    halt     = 1'b0;
    // Next-PC: (imm or 4) + (rs1 or pc); JALR drops bit 0
    sum = (a ? im : 32'd4) + (b ? r : m_pc);
    if (b) sum = sum & 32'hFFFF_FFFE;
    m_instret = m_instret + 64'd1;
`ifdef PC_MISALIGN_CHECK_EN
    if (sum % 4 != 0) begin
      m_misalign = 1'b1;
      m_halted   = 1'b1;
    end else begin
      m_pc = sum;
      if (h) m_halted = 1'b1;
    end
    chk("commit_misalign", misalign, m_misalign);
`else
    m_pc = sum;
    if (h) m_halted = 1'b1;
`endif
    chk("commit_instret", instret, m_instret);
    chk("commit_halted", halted, m_halted);
    chk("commit_inst_valid", inst_valid, 0);
    chk("commit_pc", pc, m_pc);
    chk("commit_req_valid", ifu.ifu_req_valid, !m_halted);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    bit          r_a;
    bit          r_b;

    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    ifu.ifu_rsp_inst  = '0;
    model_reset();

    // Stalled request, response one cycle after handshake, sequential commit
    do_reset();
    fetch(32'h0000_0013, 3, 1'b0, 0);
    execute(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("seq_pc", pc, 32'h8000_0004);
    chk("seq_instret", instret, 1);

    // Branch to 0x80000010, then back by -16
    fetch(32'h00C0_006F, 0, 1'b1, 0);
    execute(1'b1, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 1);
    chk("br_fwd_pc", pc, 32'h8000_0010);
    fetch(32'hFF1F_F06F, 0, 1'b0, 2);
    execute(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 0);
    chk("br_back_addr", ifu.ifu_req_addr, 32'h8000_0000);

    // JALR with odd rs1 target
    fetch(32'h0040_80E7, 1, 1'b0, 1);
    execute(1'b1, 1'b1, 32'h0000_0004, 32'h8000_1001, 1'b0, 0);
    chk("jalr_addr", ifu.ifu_req_addr, 32'h8000_1004);

    // Random traffic with aligned targets
    for (int k = 0; k < 30; k++) begin
      r_a   = 1'($urandom_range(0, 1));
      r_b   = 1'($urandom_range(0, 1));
      r_imm = $urandom & 32'hFFFF_FFFC;
      r_rs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      fetch($urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      execute(r_a, r_b, r_imm, r_b ? r_rs1 : $urandom, 1'b0, $urandom_range(0, 2));
    end

    // Halt on commit, then stay quiet
    fetch(32'h0010_0073, 0, 1'b0, 0);
    execute(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      ifu.ifu_req_ready = 1'b1;
      ifu.ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu.ifu_rsp_inst  = $urandom;
      exu_done = 1'($urandom_range(0, 1));
      pc_a_src = 1'($urandom_range(0, 1));
      imm      = $urandom;
      @(negedge clk);
      chk("halt_req_valid", ifu.ifu_req_valid, 0);
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, m_pc);
      chk("halt_instret", instret, m_instret);
    end
    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    exu_done = 1'b0;

    // Reset while waiting for a response; a late response must be dropped
    do_reset();
    fetch(32'h1111_1113, 0, 1'b0, 0);
    execute(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("pre_wait_pc", ifu.ifu_req_addr, 32'h8000_0004);
    ifu.ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu.ifu_req_ready = 1'b0;
    chk("mid_wait_req_valid", ifu.ifu_req_valid, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_pc", pc, m_pc);
    chk("async_rst_instret", instret, 0);
    chk("async_rst_state", state_dbg, S_REQ);
    @(negedge clk);
    rst = 1'b0;
    ifu.ifu_rsp_valid = 1'b1;
    ifu.ifu_rsp_inst  = 32'hDEAD_BEEF;
    @(negedge clk);
    ifu.ifu_rsp_valid = 1'b0;
    chk("late_rsp_inst_valid", inst_valid, 0);
    chk("late_rsp_req_valid", ifu.ifu_req_valid, 1);
    chk("late_rsp_addr", ifu.ifu_req_addr, 32'h8000_0000);
    chk("late_rsp_inst", inst, 0);
    fetch(32'h2222_2213, 0, 1'b1, 0);
    execute(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);

`ifdef PC_MISALIGN_CHECK_EN
    // Misaligned target: pc kept, halt with misalign flag
    do_reset();
    fetch(32'h0020_006F, 0, 1'b0, 0);
    execute(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1'b0, 0);
    chk("mis_flag", misalign, 1);
    chk("mis_pc", pc, 32'h8000_0000);
    chk("mis_instret", instret, 1);
    repeat (3) @(negedge clk);
    chk("mis_hold", misalign, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
